// File: rtl/seq_div_32.sv
// Restoring 32-bit divider: quotient and remainder in a fixed 34-cycle latency.
// The trial subtraction for every iteration shares one ripple-carry adder/subtractor.
//
// state | meaning
// IDLE  | waiting for START, last result held on Q/R/DBZ
// PREP  | operands reduced to magnitudes, iteration registers cleared
// ITER  | one quotient bit per cycle, 32 cycles
// FIX   | signs restored or divide-by-zero result loaded, DONE raised
module seq_div_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] DVD,
  input  logic [WIDTH-1:0] DVS,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             BUSY,
  output logic             DONE,
  output logic             DBZ
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} stateE;

  stateE state, stateNext;

  logic [WIDTH-1:0] dvdLat, dvsLat, dMag;
  logic [WIDTH-1:0] pRem, aQuo;
  logic [CNT_W-1:0] cnt;
  logic             signLat, sq, sr;

  logic [WIDTH-1:0] pShift, diff, absDvd, absDvs;
  logic             co, qBit;

  // Two's-complement negate as invert-plus-one on a carry chain of its own.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] res;
    logic             c;
    res = '0;
    c   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = ~x[i] ^ c;
      c      = ~x[i] & c;
    end
    return res;
  endfunction

  assign absDvd = (signLat && dvdLat[WIDTH-1]) ? negate(dvdLat) : dvdLat;
  assign absDvs = (signLat && dvsLat[WIDTH-1]) ? negate(dvsLat) : dvsLat;

  assign pShift = {pRem[WIDTH-2:0], aQuo[WIDTH-1]};

  RC_ADD_SUB_32 uAddSub (
    .A   (pShift),
    .B   (dMag),
    .SnA (1'b1),
    .S   (diff),
    .CO  (co)
  );

  // The bit shifted out of P is an implicit 33rd bit, so the trial always fits then.
  assign qBit = pRem[WIDTH-1] | co;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (START) stateNext = PREP;
      PREP: stateNext = ITER;
      ITER: if (cnt == CNT_W'(WIDTH - 1)) stateNext = FIX;
      FIX:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dvdLat  <= '0;
      dvsLat  <= '0;
      dMag    <= '0;
      pRem    <= '0;
      aQuo    <= '0;
      cnt     <= '0;
      signLat <= 1'b0;
      sq      <= 1'b0;
      sr      <= 1'b0;
      Q       <= '0;
      R       <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      DBZ     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            dvdLat  <= DVD;
            dvsLat  <= DVS;
            signLat <= SIGNED;
            sq      <= SIGNED & (DVD[WIDTH-1] ^ DVS[WIDTH-1]);
            sr      <= SIGNED & DVD[WIDTH-1];
            BUSY    <= 1'b1;
          end
        end
        PREP: begin
          pRem <= '0;
          aQuo <= absDvd;
          dMag <= absDvs;
          cnt  <= '0;
        end
        ITER: begin
          pRem <= qBit ? diff : pShift;
          aQuo <= {aQuo[WIDTH-2:0], qBit};
          cnt  <= cnt + CNT_W'(1);
        end
        FIX: begin
          if (dvsLat == '0) begin
            Q   <= '1;
            R   <= dvdLat;
            DBZ <= 1'b1;
          end else begin
            Q   <= sq ? negate(aQuo) : aQuo;
            R   <= sr ? negate(pRem) : pRem;
            DBZ <= 1'b0;
          end
          DONE <= 1'b1;
          BUSY <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// 32-bit ripple-carry adder/subtractor; SnA=1 computes A-B with CO=1 meaning no borrow.
module RC_ADD_SUB_32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        SnA,
  output logic [31:0] S,
  output logic        CO
);

  always_comb begin : rippleChain
    logic c;
    logic bi;
    S  = '0;
    c  = SnA;
    bi = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bi   = B[i] ^ SnA;
      S[i] = A[i] ^ bi ^ c;
      c    = (A[i] & bi) | (c & (A[i] ^ bi));
    end
    CO = c;
  end

endmodule

// File: tb/tb_seq_div_32.sv
// Bench for seq_div_32: arithmetic reference model checked every cycle,
// plus directed cases with literal results and latencies.
module tb_seq_div_32;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        SIGNED = 1'b0;
  logic [31:0] DVD = '0;
  logic [31:0] DVS = '0;
  logic [31:0] Q, R;
  logic        BUSY, DONE, DBZ;

  int total = 0;
  int bad = 0;

  seq_div_32 dut (
    .CLK(CLK), .RST(RST), .START(START), .SIGNED(SIGNED),
    .DVD(DVD), .DVS(DVS), .Q(Q), .R(R),
    .BUSY(BUSY), .DONE(DONE), .DBZ(DBZ)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from integer arithmetic.
  task automatic refDiv(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      q = qq[31:0]; r = rr[31:0]; z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  // Model: an accepted request completes 34 edges later; requests while active are dropped.
  logic        mActive = 1'b0;
  int          mLeft = 0;
  logic [31:0] mPendQ = '0, mPendR = '0;
  logic        mPendZ = 1'b0;
  logic [31:0] eQ = '0, eR = '0;
  logic        eBusy = 1'b0, eDone = 1'b0, eZ = 1'b0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mActive = 1'b0; mLeft = 0;
      eQ = '0; eR = '0; eBusy = 1'b0; eDone = 1'b0; eZ = 1'b0;
    end else begin
      eDone = 1'b0;
      if (mActive) begin
        mLeft--;
        if (mLeft == 0) begin
          mActive = 1'b0;
          eDone = 1'b1;
          eQ = mPendQ; eR = mPendR; eZ = mPendZ;
        end
      end else if (START) begin
        mActive = 1'b1;
        mLeft = 34;
        refDiv(DVD, DVS, SIGNED, mPendQ, mPendR, mPendZ);
      end
      eBusy = mActive;
    end
  end

  always @(negedge CLK) begin
    check("busy", {31'd0, BUSY}, {31'd0, eBusy});
    check("done", {31'd0, DONE}, {31'd0, eDone});
    check("dbz", {31'd0, DBZ}, {31'd0, eZ});
    check("q", Q, eQ);
    check("r", R, eR);
  end

  // One-cycle START, then wait for DONE; checks literal results and the 34-edge latency.
  task automatic doOp(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] xq, input logic [31:0] xr, input logic xz);
    int n;
    n = 0;
    @(negedge CLK);
    DVD = a; DVS = b; SIGNED = s; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check({nm, "_busy0"}, {31'd0, BUSY}, 32'd1);
    while (!DONE && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check({nm, "_lat"}, n, 32'd34);
    check({nm, "_q"}, Q, xq);
    check({nm, "_r"}, R, xr);
    check({nm, "_dbz"}, {31'd0, DBZ}, {31'd0, xz});
    @(negedge CLK);
    check({nm, "_donepulse"}, {31'd0, DONE}, 32'd0);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((BUSY || DONE) && n < 80) begin
      @(negedge CLK);
      n++;
    end
    check("idle_timeout", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] specials [8];
    logic [31:0] a, b;
    specials[0] = 32'h8000_0000; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'd0;
    specials[3] = 32'd1;         specials[4] = 32'h7FFF_FFFF; specials[5] = 32'd7;
    specials[6] = 32'hFFFF_FFF9; specials[7] = 32'h8000_0001;

    repeat (3) @(negedge CLK);
    check("rst_q", Q, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    #2 RST = 1'b1;
    @(negedge CLK);

    doOp("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    doOp("sm100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    doOp("s100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0);
    doOp("dbz_u", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    doOp("dbz_s", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    doOp("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    doOp("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    doOp("u5_max", 32'd5, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd5, 1'b0);
    doOp("u_msb", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd1, 32'h7FFF_FFFF, 1'b0);

    // START during an operation is ignored.
    @(negedge CLK);
    DVD = 32'd1000; DVS = 32'd7; SIGNED = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    DVD = 32'd5; DVS = 32'd1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 0;
    while (!DONE && n < 40) begin @(negedge CLK); n++; end
    check("ign_q", Q, 32'd142);
    check("ign_r", R, 32'd6);
    waitIdle();

    // START held through the DONE cycle: back-to-back results 35 edges apart.
    @(negedge CLK);
    DVD = 32'd50; DVS = 32'd5; SIGNED = 1'b0; START = 1'b1;
    @(negedge CLK);
    DVD = 32'd77; DVS = 32'd10;
    n = 0;
    while (!DONE && n < 40) begin @(negedge CLK); n++; end
    check("b2b_q1", Q, 32'd10);
    check("b2b_r1", R, 32'd0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (n == 1) START = 1'b0;
    end while (!DONE && n < 50);
    check("b2b_gap", n, 32'd35);
    check("b2b_q2", Q, 32'd7);
    check("b2b_r2", R, 32'd7);
    waitIdle();

    // Reset between edges 20 and 21 aborts the operation.
    @(negedge CLK);
    DVD = 32'hFFFF_FF9C; DVS = 32'd0; SIGNED = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (20) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("ar_q", Q, 32'd0);
    check("ar_r", R, 32'd0);
    check("ar_busy", {31'd0, BUSY}, 32'd0);
    check("ar_dbz", {31'd0, DBZ}, 32'd0);
    @(posedge CLK);
    #2 RST = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE) n++;
    end
    check("ar_nodone", n, 32'd0);
    doOp("after_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

    // Random operations with random gaps; the model covers starts that land mid-operation.
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
      case ($urandom_range(0, 3))
        0: b = specials[$urandom_range(0, 7)];
        1: b = $urandom_range(0, 15);
        default: b = $urandom;
      endcase
      @(negedge CLK);
      DVD = a; DVS = b; SIGNED = 1'($urandom_range(0, 1)); START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat ($urandom_range(1, 45)) @(negedge CLK);
    end
    waitIdle();
    repeat (2) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_div_32.md
Name: seq_div_32

Overview:
- Multi-cycle 32-bit integer divider for the ALU's DIV/DIVU path.
- Produces quotient and remainder in a fixed 34-cycle latency using restoring division, one quotient bit per cycle.
- Each iteration's trial subtraction goes through one instance of the codebase's 32-bit ripple-carry adder/subtractor (RC_ADD_SUB_32, SnA=1).
- The control unit drives START and stalls on BUSY.

Parameters:
- WIDTH, 32, operand/result width; only 32 supported.
- CNT_W, 6, iteration counter width.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE.
- SIGNED  input  1  1 = two's-complement divide, 0 = unsigned.
- DVD  input  32  dividend; sampled with START.
- DVS  input  32  divisor; sampled with START.
- Q  output  32  quotient; registered.
- R  output  32  remainder; registered.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse when Q/R are valid.
- DBZ  output  1  divide-by-zero flag for the last operation.

Behaviour:
- Reset:
  - RST low, regardless of CLK: Q=0, R=0, BUSY=0, DONE=0, DBZ=0, state=IDLE, counter=0.
  - Reset mid-operation aborts the operation; no DONE is produced.
- States: IDLE, PREP, ITER, FIX.
- IDLE:
  - On an edge with START=1: latch DVD, DVS and SIGNED; record sign flags sq = SIGNED & (DVD[31]^DVS[31]) and sr = SIGNED & DVD[31]; BUSY<=1; go to PREP.
  - START=0: stay in IDLE.
- PREP (1 cycle):
  - When SIGNED, replace each operand by its magnitude (negate if negative). 0x80000000 stays 0x80000000 and is treated as unsigned 2^31.
  - Partial remainder P<=0, quotient shift register A<=|DVD|, counter<=0; go to ITER.
- ITER (exactly 32 cycles), per cycle:
  - Form P' = {P[30:0], A[31]}.
  - Compute diff = P' - D on the adder/subtractor, giving CO.
  - Let msb = P[31] (the bit shifted out).
  - If msb | CO: P<=diff and the quotient bit is 1. Otherwise P<=P' and the quotient bit is 0.
  - A <= {A[30:0], qbit}; counter++.
  - After the 32nd iteration, go to FIX.
- FIX (1 cycle):
  - Normal case: Q <= sq ? -A : A; R <= sr ? -P : P; DBZ<=0.
  - DVS==0 (zero test on the latched divisor): Q<=0xFFFFFFFF, R<=DVD (original, unmodified), DBZ<=1, for both SIGNED values.
  - Same edge: DONE<=1, BUSY<=0, go to IDLE.
- DONE clears on the following edge.
- Latency: START sampled at edge 0 gives DONE high after edge 34; Q/R are valid from that cycle.
- Q/R/DBZ hold until the next FIX or reset.
- START while BUSY=1 is ignored; no queueing, and latched operands are unaffected.
- START high during the DONE cycle is accepted: state is IDLE then, so back-to-back throughput is one result per 35 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: Q=0x80000000, R=0, DBZ=0. No trap.
- Remainder sign follows the dividend; quotient truncates toward zero.
- Only one adder/subtractor instance; no other arithmetic operators in the datapath. Negations use invert-plus-one through a dedicated increment path.

Test Plan:
1. Unsigned: SIGNED=0, DVD=100, DVS=7, one-cycle START -> BUSY=1 from edge 0; DONE pulses exactly one cycle after edge 34; Q=14, R=2, DBZ=0.
2. Signed: DVD=0xFFFFFF9C (-100), DVS=7 -> Q=0xFFFFFFF2 (-14), R=0xFFFFFFFE (-2). Then DVD=100, DVS=0xFFFFFFF9 (-7) -> Q=0xFFFFFFF2, R=2.
3. Divide by zero: DVD=0x12345678, DVS=0, both SIGNED=0 and SIGNED=1 -> Q=0xFFFFFFFF, R=0x12345678, DBZ=1, same 34-edge latency.
4. Corner values:
   - Signed 0x80000000/0xFFFFFFFF -> Q=0x80000000, R=0.
   - Unsigned 0xFFFFFFFF/1 -> Q=0xFFFFFFFF, R=0.
   - Unsigned 5/0xFFFFFFFF -> Q=0, R=5.
   - Unsigned 0xFFFFFFFF/0x80000000 -> Q=1, R=0x7FFFFFFF (exercises the msb path).
5. Handshake:
   - START at edge 10 of an operation, with different operands -> ignored; first result unchanged.
   - START held high through the DONE cycle with new operands -> second operation's DONE exactly 35 edges after the first DONE.
6. Reset: assert RST low between edges 20 and 21 of an operation -> Q=R=0, BUSY=DONE=DBZ=0 immediately, no DONE afterwards. After release, 9/3 -> Q=3, R=0.
